// File: rtl/alu_issue_stage.sv
// Issue/execute/writeback feeder for the 4-bit combinational ALU: regfile read, EX register, WB update.
// Optional macro ALU_BYPASS_EN: forward alu_result to a dependent operand instead of stalling one cycle.
module alu_issue_stage #(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [WIDTH-1:0]  in_imm,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_op,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [WIDTH-1:0]  wb_data,
  output logic              zero_flag,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic                        ex_valid;
  logic [ADDR_W-1:0]           ex_rd;
  logic [WIDTH-1:0]            opa, opb;
  logic                        hit1, hit2, accept;

  // Source matches the op currently in EX, whose result is not yet in the array.
  assign hit1 = ex_valid && (in_rs1 == ex_rd);
  assign hit2 = ex_valid && !in_use_imm && (in_rs2 == ex_rd);

`ifdef ALU_BYPASS_EN
  assign in_ready = ~rst;
  assign opa      = hit1 ? alu_result : regs[in_rs1];
  assign opb      = in_use_imm ? in_imm : (hit2 ? alu_result : regs[in_rs2]);
`else
  assign in_ready = ~rst & ~(hit1 | hit2);
  assign opa      = regs[in_rs1];
  assign opb      = in_use_imm ? in_imm : regs[in_rs2];
`endif

  assign accept   = in_valid & in_ready;
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs      <= '0;
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      zero_flag <= 1'b0;
    end else begin
      ex_valid <= accept;
      wb_valid <= ex_valid;
      // alu_* hold their last value while EX is empty.
      if (accept) begin
        alu_a  <= opa;
        alu_b  <= opb;
        alu_op <= in_op;
        ex_rd  <= in_rd;
      end
      if (ex_valid) begin
        regs[ex_rd] <= alu_result;
        wb_rd       <= ex_rd;
        wb_data     <= alu_result;
        zero_flag   <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Random + directed bench for alu_issue_stage against an in-order architectural model and a stub ALU.
module tb_alu_issue_stage;
  localparam int W = 4, N = 4, AW = 2;
`ifdef ALU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid, in_ready, in_use_imm, alu_zero, wb_valid, zero_flag;
  logic [2:0] in_op, alu_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2, wb_rd, dbg_addr;
  logic [W-1:0] in_imm, alu_a, alu_b, alu_result, wb_data, dbg_data;

  alu_issue_stage #(.WIDTH(W), .NREGS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  always #5 clk = ~clk;

  // Stub of the external 4-bit ALU; results wrap at 4 bits.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return W'(a + b);
      3'd1:    return W'(a - b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[W-2:0], 1'b0};
      3'd6:    return ~a;
      default: return b;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == '0);
  end

  typedef struct { int due; logic [AW-1:0] rd; logic [W-1:0] data; logic z; } wb_t;
  typedef struct { int due; logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; } ex_t;
  wb_t wbq[$];
  ex_t exq[$];
  logic [W-1:0] arch [N];  // program-order register values
  logic [W-1:0] cmt  [N];  // values the array should hold after completed writebacks
  logic [W-1:0] last_a, last_b;
  logic [2:0]   last_op;
  logic         last_z, ex_busy;
  logic [AW-1:0] ex_rd_m;
  int cyc, n_cmp, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin arch[i] = '0; cmt[i] = '0; end
    wbq.delete(); exq.delete();
    last_a = '0; last_b = '0; last_op = '0; last_z = 1'b0; ex_busy = 1'b0; ex_rd_m = '0;
  endtask

  task automatic check_outs();
    wb_t w;
    ex_t e;
    if (wbq.size() > 0 && wbq[0].due == cyc) begin
      w = wbq.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_rd", 32'(wb_rd), 32'(w.rd));
      chk("wb_data", 32'(wb_data), 32'(w.data));
      cmt[w.rd] = w.data;
      last_z = w.z;
    end else chk("wb_valid_idle", 32'(wb_valid), 32'd0);
    chk("zero_flag", 32'(zero_flag), 32'(last_z));
    if (exq.size() > 0 && exq[0].due == cyc) begin
      e = exq.pop_front();
      last_a = e.a; last_b = e.b; last_op = e.op;
    end
    chk("alu_a", 32'(alu_a), 32'(last_a));
    chk("alu_b", 32'(alu_b), 32'(last_b));
    chk("alu_op", 32'(alu_op), 32'(last_op));
  endtask

  // One cycle: check outputs at the falling edge, then present the next request.
  task automatic step(input bit v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input bit ui, input logic [W-1:0] imm,
                      input logic [2:0] op, output bit acc);
    logic exp_rdy;
    logic [W-1:0] a, b, r;
    @(negedge clk);
    cyc++;
    check_outs();
    in_valid = v; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = ui; in_imm = imm; in_op = op;
    dbg_addr = AW'($urandom_range(0, N-1));
    #1;
    chk("dbg_data", 32'(dbg_data), 32'(cmt[dbg_addr]));
    exp_rdy = BYP ? 1'b1 : !(ex_busy && (rs1 == ex_rd_m || (!ui && rs2 == ex_rd_m)));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && in_ready;
    ex_busy = acc; ex_rd_m = rd;
    if (acc) begin
      a = arch[rs1];
      b = ui ? imm : arch[rs2];
      r = alu_fn(a, b, op);
      arch[rd] = r;
      exq.push_back('{cyc + 1, a, b, op});
      wbq.push_back('{cyc + 2, rd, r, (r == '0)});
    end
  endtask

  task automatic idle();
    bit acc;
    step(1'b0, AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1)),
         AW'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)), '0, '0, acc);
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input bit ui, input logic [W-1:0] imm, input logic [2:0] op, output int tries);
    bit acc;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 5) begin
      step(1'b1, rd, rs1, rs2, ui, imm, op, acc);
      tries++;
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_dbg(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    int t;
    bit acc;
    n_cmp = 0; n_err = 0; cyc = 0;
    in_valid = 0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 0; in_imm = '0; dbg_addr = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_zero_flag", 32'(zero_flag), 32'd0);
    for (int i = 0; i < N; i++) rd_dbg("rst_reg", AW'(i), '0);

    // r1 = r0 + 5, then dependent r2 = r1 + r1
    issue(2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 3'd0, t);
    chk("first_tries", 32'(t), 32'd1);
    issue(2'd2, 2'd1, 2'd1, 1'b0, 4'd0, 3'd0, t);
    chk("raw_tries", 32'(t), BYP ? 32'd1 : 32'd2);
    issue(2'd3, 2'd1, 2'd0, 1'b1, 4'd12, 3'd0, t);
    issue(2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd0, t);
    repeat (3) idle();
    rd_dbg("r1_is_5", 2'd1, 4'd5);
    rd_dbg("r2_is_10", 2'd2, 4'd10);
    rd_dbg("r3_wraps_1", 2'd3, 4'd1);
    chk("zero_after_r0", 32'(zero_flag), 32'd1);

    // Reset while an op sits in EX: no writeback, destination cleared
    issue(2'd3, 2'd0, 2'd0, 1'b1, 4'd7, 3'd0, t);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("midrst_wb_valid2", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    rd_dbg("midrst_r3", 2'd3, '0);
    rd_dbg("midrst_r1", 2'd1, '0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Four independent ops back-to-back: consecutive, in-order writebacks
    step(1'b1, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3, 3'd0, acc); chk("stream0", 32'(acc), 32'd1);
    step(1'b1, 2'd2, 2'd0, 2'd0, 1'b1, 4'd9, 3'd4, acc); chk("stream1", 32'(acc), 32'd1);
    step(1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 4'd0, 3'd6, acc); chk("stream2", 32'(acc), 32'd1);
    step(1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0, 3'd7, acc); chk("stream3", 32'(acc), 32'd1);
    repeat (3) idle();
    rd_dbg("stream_r3", 2'd3, 4'hF);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1)),
           AW'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), acc);
    repeat (3) idle();
    chk("drain_wbq", 32'(wbq.size()), 32'd0);
    for (int i = 0; i < N; i++) rd_dbg("final_reg", AW'(i), arch[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
